// File: rtl/wb_burst_ctrl.sv
// Wishbone slave front end for the 16-word burst line buffer: captures the request,
// starts the burst incrementer and acks beats. Optional macro WB_BURST_ERR_EN adds wb_err_o.
module wb_burst_ctrl #(
    parameter int unsigned WAIT_CYC = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] wb_adr_i,
    input  logic [2:0] wb_cti_i,
    input  logic [1:0] wb_bte_i,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    output logic       wb_ack_o,
    input  logic       buf_rdy_i,
    output logic [3:0] adr_o,
    output logic [2:0] cti_o,
    output logic [1:0] bte_o,
    output logic       init_o,
    output logic       inc_o,
    input  logic       done_i,
    output logic       we_o
`ifdef WB_BURST_ERR_EN
    ,
    output logic       wb_err_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_WAIT,
        S_BURST
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] wait_cnt, wait_nxt;
    logic [4:0] beat_cnt, beat_nxt;
    logic       capture;
    logic       req;
    logic       strobe;
    logic       ack;
    logic       beat_err;
    logic       guard_last;
    logic       last_beat;

    assign req    = wb_cyc_i & wb_stb_i & buf_rdy_i;
    // Combinational so a strobe dropped in the same cycle is never acked.
    assign strobe = wb_cyc_i & wb_stb_i & (state == S_BURST);

`ifdef WB_BURST_ERR_EN
    logic unsup_cti;
    assign unsup_cti  = (cti_o == 3'b001) || ((cti_o >= 3'b011) && (cti_o <= 3'b110));
    // A 17th strobed beat is answered with an error instead of an ack.
    assign beat_err   = unsup_cti | (beat_cnt == 5'd16);
    assign guard_last = 1'b0;
    assign wb_err_o   = strobe & beat_err;
`else
    assign beat_err   = 1'b0;
    // Silent guard: the 16th ack closes the burst.
    assign guard_last = (beat_cnt == 5'd15);
`endif

    assign ack      = strobe & ~beat_err;
    assign wb_ack_o = ack;
    assign inc_o    = ack;

    // Anything other than an incrementing burst gets exactly one beat.
    assign last_beat = done_i | (wb_cti_i == 3'b111) | (cti_o != 3'b010) | guard_last;

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        beat_nxt  = beat_cnt;
        init_o    = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt = S_INIT;
                    capture   = 1'b1;
                end
            end
            S_INIT: begin
                init_o    = 1'b1;
                wait_nxt  = 3'(WAIT_CYC - 1);
                beat_nxt  = 5'd0;
                state_nxt = (WAIT_CYC == 1) ? S_BURST : S_WAIT;
            end
            S_WAIT: begin
                wait_nxt = wait_cnt - 3'd1;
                if (wait_cnt == 3'd1)
                    state_nxt = S_BURST;
            end
            S_BURST: begin
                if (ack) begin
                    beat_nxt = beat_cnt + 5'd1;
                    if (last_beat)
                        state_nxt = S_IDLE;
                end else if (strobe) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Losing cyc aborts from anywhere outside IDLE.
        if ((state != S_IDLE) && !wb_cyc_i)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            wait_cnt <= 3'd0;
            beat_cnt <= 5'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adr_o <= 4'd0;
            cti_o <= 3'b000;
            bte_o <= 2'b00;
            we_o  <= 1'b0;
        end else if (capture) begin
            adr_o <= wb_adr_i;
            cti_o <= wb_cti_i;
            bte_o <= wb_bte_i;
            we_o  <= wb_we_i;
        end
    end

endmodule

// File: tb/tb_wb_burst_ctrl.sv
// Bench for wb_burst_ctrl: directed cycle tables, reset sequences and a randomized
// transaction-level model of the request/ack protocol.
module tb_wb_burst_ctrl;

    localparam int W = 3;
`ifdef WB_BURST_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] wb_adr_i = '0;
    logic [2:0] wb_cti_i = '0;
    logic [1:0] wb_bte_i = '0;
    logic       wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic       buf_rdy_i = 1'b0, done_i = 1'b0;
    logic       wb_ack_o, init_o, inc_o, we_o;
    logic [3:0] adr_o;
    logic [2:0] cti_o;
    logic [1:0] bte_o;
`ifdef WB_BURST_ERR_EN
    logic       wb_err_o;
`endif

    wb_burst_ctrl #(.WAIT_CYC(W)) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_ack_o(wb_ack_o), .buf_rdy_i(buf_rdy_i),
        .adr_o(adr_o), .cti_o(cti_o), .bte_o(bte_o),
        .init_o(init_o), .inc_o(inc_o), .done_i(done_i), .we_o(we_o)
`ifdef WB_BURST_ERR_EN
        , .wb_err_o(wb_err_o)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit cyc, stb, rdy, done;
        logic [3:0] adr;
        logic [2:0] cti;
        logic [1:0] bte;
        bit e_init, e_ack, e_err;
        logic [3:0] e_adr;
    } vec_t;

    vec_t vt[$];

    task automatic add(input bit c, s, r, d, input logic [3:0] a, input logic [2:0] ct,
                       input logic [1:0] b, input bit ei, ea, ee, input logic [3:0] ead);
        vec_t v;
        v.cyc = c; v.stb = s; v.rdy = r; v.done = d;
        v.adr = a; v.cti = ct; v.bte = b;
        v.e_init = ei; v.e_ack = ea; v.e_err = ee; v.e_adr = ead;
        vt.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Random-section working variables (static, assigned each iteration).
    logic [3:0] ra;
    logic [2:0] rc, lc;
    logic [1:0] rb;
    bit rw, rr, c, s, d, fin, unsup, classic, e_init, e_ack, e_err;
    int beats, t;

    initial begin
        // Reset held with a live request: every output stays quiet.
        rst = 1'b0; wb_cyc_i = 1; wb_stb_i = 1; buf_rdy_i = 1; wb_adr_i = 0; wb_cti_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ack", wb_ack_o, 0);
        chk("rst inc", inc_o, 0);
        chk("rst init", init_o, 0);
        chk("rst we", we_o, 0);
        chk("rst adr", adr_o, 0);
        chk("rst cti", cti_o, 0);
        chk("rst bte", bte_o, 0);
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("rst init pulse", init_o, 1);
        next_cycle();
        wb_cyc_i = 0; wb_stb_i = 0;
        @(negedge clk);
        chk("rst init single", init_o, 0);
        chk("rst no ack", wb_ack_o, 0);
        next_cycle();

        // Classic read, adr 5
        add(1,1,1,0,5,3'b000,0, 0,0,0, 0);
        add(1,1,0,0,5,3'b000,0, 1,0,0, 5);
        add(1,1,0,0,5,3'b000,0, 0,0,0, 5);
        add(1,1,0,0,5,3'b000,0, 0,0,0, 5);
        add(1,1,0,0,5,3'b000,0, 0,1,0, 5);
        add(0,0,0,0,0,3'b000,0, 0,0,0, 5);
        // 4-beat wrap, done on 4th ack, 5th strobe unacked
        add(1,1,1,0,2,3'b010,1, 0,0,0, 5);
        add(1,1,1,0,2,3'b010,1, 1,0,0, 2);
        add(1,1,1,0,2,3'b010,1, 0,0,0, 2);
        add(1,1,1,0,2,3'b010,1, 0,0,0, 2);
        for (int i = 0; i < 3; i++) add(1,1,1,0,2,3'b010,1, 0,1,0, 2);
        add(1,1,1,1,2,3'b010,1, 0,1,0, 2);
        add(1,1,0,0,2,3'b010,1, 0,0,0, 2);
        add(0,0,0,0,0,3'b000,0, 0,0,0, 2);
        // Wait states mid-burst, end-of-burst cti closes it
        add(1,1,1,0,7,3'b010,0, 0,0,0, 2);
        add(1,1,0,0,7,3'b010,0, 1,0,0, 7);
        add(1,1,0,0,7,3'b010,0, 0,0,0, 7);
        add(1,1,0,0,7,3'b010,0, 0,0,0, 7);
        add(1,1,0,0,7,3'b010,0, 0,1,0, 7);
        add(1,0,0,0,7,3'b010,0, 0,0,0, 7);
        add(1,0,0,0,7,3'b010,0, 0,0,0, 7);
        add(1,1,0,0,7,3'b010,0, 0,1,0, 7);
        add(1,1,0,0,7,3'b111,0, 0,1,0, 7);
        add(0,0,0,0,0,3'b000,0, 0,0,0, 7);
        // Abort in WAIT, re-request, abort in BURST, then buffer not ready
        add(1,1,1,0,3,3'b010,0, 0,0,0, 7);
        add(1,1,1,0,3,3'b010,0, 1,0,0, 3);
        add(0,0,1,0,3,3'b010,0, 0,0,0, 3);
        add(1,1,1,0,4,3'b010,0, 0,0,0, 3);
        add(1,1,1,0,4,3'b010,0, 1,0,0, 4);
        add(1,1,1,0,4,3'b010,0, 0,0,0, 4);
        add(1,1,1,0,4,3'b010,0, 0,0,0, 4);
        add(0,1,1,0,4,3'b010,0, 0,0,0, 4);
        for (int i = 0; i < 3; i++) add(1,1,0,0,8,3'b010,0, 0,0,0, 4);
        // Unsupported cti 001: classic ack, or a single error
        add(1,1,1,0,9,3'b001,0, 0,0,0, 4);
        add(1,1,0,0,9,3'b001,0, 1,0,0, 9);
        add(1,1,0,0,9,3'b001,0, 0,0,0, 9);
        add(1,1,0,0,9,3'b001,0, 0,0,0, 9);
        add(1,1,0,0,9,3'b001,0, 0,!ERR,ERR, 9);
        add(0,0,0,0,0,3'b000,0, 0,0,0, 9);
        // Beat guard: 17 strobed beats, no done
        add(1,1,1,0,0,3'b010,0, 0,0,0, 9);
        add(1,1,0,0,0,3'b010,0, 1,0,0, 0);
        add(1,1,0,0,0,3'b010,0, 0,0,0, 0);
        add(1,1,0,0,0,3'b010,0, 0,0,0, 0);
        for (int i = 0; i < 16; i++) add(1,1,0,0,0,3'b010,0, 0,1,0, 0);
        add(1,1,0,0,0,3'b010,0, 0,0,ERR, 0);
        add(1,1,0,0,0,3'b010,0, 0,0,0, 0);
        add(0,0,0,0,0,3'b000,0, 0,0,0, 0);

        foreach (vt[i]) begin
            wb_cyc_i = vt[i].cyc; wb_stb_i = vt[i].stb; buf_rdy_i = vt[i].rdy;
            done_i = vt[i].done; wb_adr_i = vt[i].adr; wb_cti_i = vt[i].cti;
            wb_bte_i = vt[i].bte; wb_we_i = 0;
            @(negedge clk);
            chk($sformatf("vec[%0d] init", i), init_o, vt[i].e_init);
            chk($sformatf("vec[%0d] ack", i), wb_ack_o, vt[i].e_ack);
            chk($sformatf("vec[%0d] inc", i), inc_o, vt[i].e_ack);
            chk($sformatf("vec[%0d] adr", i), adr_o, vt[i].e_adr);
`ifdef WB_BURST_ERR_EN
            chk($sformatf("vec[%0d] err", i), wb_err_o, vt[i].e_err);
`endif
            next_cycle();
        end

        // Asynchronous reset in the middle of a burst
        wb_cyc_i = 1; wb_stb_i = 1; buf_rdy_i = 1; wb_adr_i = 6; wb_cti_i = 3'b010; done_i = 0;
        repeat (4) next_cycle();
        @(negedge clk);
        chk("midrst ack before", wb_ack_o, 1);
        #2 rst = 1'b0;
        #1;
        chk("midrst ack", wb_ack_o, 0);
        chk("midrst inc", inc_o, 0);
        chk("midrst init", init_o, 0);
        chk("midrst adr", adr_o, 0);
        wb_cyc_i = 0; wb_stb_i = 0;
        rst = 1'b1;
        next_cycle();
        wb_cyc_i = 1; wb_stb_i = 1;
        @(negedge clk);
        chk("midrst idle ack", wb_ack_o, 0);
        chk("midrst idle init", init_o, 0);
        next_cycle();
        wb_cyc_i = 0; wb_stb_i = 0;
        @(negedge clk);
        chk("midrst restart init", init_o, 1);
        next_cycle();
        next_cycle();

        // Randomized transactions against a transaction-level model
        for (int n = 0; n < 300; n++) begin
            ra = 4'($urandom);
            rb = 2'($urandom);
            rw = 1'($urandom);
            case ($urandom % 8)
                0: rc = 3'b000;
                1: rc = 3'b001;
                2: rc = 3'b111;
                3: rc = 3'b100;
                default: rc = 3'b010;
            endcase
            rr = ($urandom % 8) != 0;
            unsup = !(rc inside {3'b000, 3'b010, 3'b111});
            classic = (rc != 3'b010);
            beats = 0;
            fin = 0;
            wb_cyc_i = 1; wb_stb_i = 1; buf_rdy_i = rr; wb_adr_i = ra;
            wb_cti_i = rc; wb_bte_i = rb; wb_we_i = rw; done_i = 0;
            @(negedge clk);
            chk("rnd req init", init_o, 0);
            chk("rnd req ack", wb_ack_o, 0);
            next_cycle();
            t = 1;
            while (rr && !fin && t < 400) begin
                c = ($urandom % 20) != 0;
                s = ($urandom % 4) != 0;
                d = ($urandom % 8) == 0;
                lc = (($urandom % 12) == 0) ? 3'b111 : 3'b010;
                e_init = (t == 1);
                e_ack = 0;
                e_err = 0;
                if (!c) begin
                    fin = 1;
                end else if (s && t >= W + 1) begin
                    if (ERR && (unsup || beats == 16)) begin
                        e_err = 1;
                        fin = 1;
                    end else begin
                        e_ack = 1;
                        beats++;
                        if (d || lc == 3'b111 || classic || (!ERR && beats == 16))
                            fin = 1;
                    end
                end
                wb_cyc_i = c; wb_stb_i = s; done_i = d; wb_cti_i = lc;
                buf_rdy_i = 1'($urandom); wb_adr_i = 4'($urandom); wb_we_i = 1'($urandom);
                @(negedge clk);
                chk("rnd init", init_o, e_init);
                chk("rnd ack", wb_ack_o, e_ack);
                chk("rnd inc", inc_o, e_ack);
`ifdef WB_BURST_ERR_EN
                chk("rnd err", wb_err_o, e_err);
`endif
                if (t == 1) begin
                    chk("rnd adr", adr_o, ra);
                    chk("rnd cti", cti_o, rc);
                    chk("rnd bte", bte_o, rb);
                    chk("rnd we", we_o, rw);
                end
                next_cycle();
                t++;
            end
            if (rr)
                chk("rnd finished", fin, 1);
            wb_cyc_i = 0; wb_stb_i = 0; done_i = 0;
            @(negedge clk);
            chk("rnd idle ack", wb_ack_o, 0);
            chk("rnd idle init", init_o, 0);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_burst_ctrl.md
# wb_burst_ctrl

Wishbone slave front end for the 16-word burst line buffer of the memory controller. It accepts classic and incrementing-burst cycles, registers the start address, cycle type and burst type, and sequences the burst address incrementer through `init_o` and `inc_o`. It generates `wb_ack_o` with a fixed first-beat latency, then terminates the burst on the incrementer's `done_i`, an end-of-burst `cti`, or loss of `cyc`/`stb`. It sits between the Wishbone bus and the burst address incrementer that drives the line-buffer RAM.

## Interface
Parameters:
- `WAIT_CYC`, default 3: cycles from `init_o` to the first possible ack (covers the incrementer's init delay plus RAM read latency); legal range 1..7.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wb_adr_i`  in  4  word index within the line.
- `wb_cti_i`  in  3  Wishbone cycle type.
- `wb_bte_i`  in  2  Wishbone burst type.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i`  in  1 each  Wishbone controls.
- `wb_ack_o`  out  1  Wishbone acknowledge.
- `buf_rdy_i`  in  1  line buffer valid and available.
- `adr_o`  out  4  captured start address, to the incrementer.
- `cti_o`  out  3  captured cycle type, to the incrementer.
- `bte_o`  out  2  captured burst type, to the incrementer.
- `init_o`  out  1  one-cycle start pulse to the incrementer.
- `inc_o`  out  1  advance the incrementer; equals `wb_ack_o`.
- `done_i`  in  1  incrementer reports the last beat.
- `we_o`  out  1  captured `wb_we_i`, to the buffer RAM.

## Operation
- States: IDLE, INIT, WAIT, BURST.
- **IDLE.** Moves to INIT when `wb_cyc_i & wb_stb_i & buf_rdy_i`. On that edge it registers `adr_o`, `cti_o`, `bte_o` and `we_o`. Without `buf_rdy_i` it stays in IDLE and never acks.
- **INIT.** `init_o`=1 for exactly this one cycle. Loads the wait counter with `WAIT_CYC-1` and clears the beat counter. Goes to WAIT, or directly to BURST when `WAIT_CYC`=1.
- **WAIT.** Decrements the wait counter and goes to BURST when it reaches 0. `wb_stb_i` is ignored here.
- **BURST.** `wb_ack_o` = `wb_cyc_i & wb_stb_i & state==BURST`. This term is combinational so that a dropped strobe is never acked.
  - Each ack increments the 5-bit beat counter.
  - Leaves for IDLE after an ack when `done_i`=1, when `wb_cti_i`=3'b111, or when the registered `cti_o`=3'b000 (classic: exactly one ack).
  - `wb_cyc_i`=0 in any non-IDLE state forces IDLE on the next edge with no ack.
  - `wb_stb_i`=0 with `wb_cyc_i`=1 in BURST is a wait state: hold, no ack, no inc.
- **Beat guard.** When the beat counter reaches 16 without a terminating condition, the block returns to IDLE. See Configuration for the error variant.
- `cti_o` values 3'b001 and 3'b011..3'b110 (unsupported) are treated as 3'b000.
- A new request is not accepted in the cycle the block returns to IDLE. It is sampled on the following edge.

## Timing
- Reset values: `wb_ack_o`, `inc_o`, `init_o` and `we_o` are 0; `adr_o` = 4'd0; `cti_o` = 3'b000; `bte_o` = 2'b00; state = IDLE; both counters are 0.
- With the request sampled at edge T0:
  - `init_o` is high during cycle T0+1.
  - The first possible ack is in cycle T0+1+`WAIT_CYC`.
  - With `WAIT_CYC`=3 and the request held, the first ack is at T0+4.
- Burst throughput is one ack per cycle while `stb` is held.
- Classic cycle latency is `WAIT_CYC`+1 cycles from request to ack.
- `done_i` is sampled in the same cycle as the ack it qualifies.
- When `done_i` and `cyc` deassertion coincide, `cyc` deassertion takes priority (no ack).
- Reset asserted mid-burst immediately drops `ack`/`inc`/`init`. The block restarts in IDLE.

## Configuration
- Macro `WB_BURST_ERR_EN` adds port `wb_err_o` (out, 1, reset 0).
- **With the macro defined:**
  - Unsupported `cti` values are answered with a single `wb_err_o` pulse, timed like a classic ack. `wb_ack_o` and `inc_o` stay 0 for that cycle.
  - A beat-counter overflow (a 17th strobed beat) asserts `wb_err_o` for that beat instead of `ack`, then the block returns to IDLE.
- **Without the macro:** `wb_err_o` does not exist. Unsupported `cti` behaves as classic, and overflow silently returns to IDLE without acking further beats.

## Test plan
- Reset: hold `rst`=0 with `cyc`/`stb`=1 -> all outputs 0; after release with `buf_rdy_i`=1, `init_o` pulses exactly one cycle.
- Classic read: adr=5, cti=000, `WAIT_CYC`=3 -> `init_o` at T+1, a single ack at T+4, `adr_o`=5, back to IDLE at T+5.
- 4-beat wrap: bte=01, cti=010, adr=2, `done_i` driven on the 4th ack -> 4 consecutive acks and 4 `inc_o` pulses; the 5th `stb` cycle is unacked.
- Wait states: `stb` low for 2 cycles mid-burst -> no ack or inc during those cycles; the burst resumes with the beat count preserved.
- Abort: `cyc` drops in WAIT and again in BURST -> no ack, IDLE the next cycle; `buf_rdy_i`=0 -> no `init_o` ever.
- `WB_BURST_ERR_EN`: cti=001 -> one `wb_err_o`, no ack; bte=00, cti=010 held for 17 beats with no `done_i` -> 16 acks then `wb_err_o`.
